// File: rtl/braille_pkg.sv
// Shared definitions for the braille scroll display: blank cell, FSM states
// and the 4-bit symbol to 6-dot cell decoder.
package braille_pkg;

    localparam logic [5:0] BLANK = 6'b000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD,
        S_DWELL
    } state_t;

    function automatic logic [5:0] decode(input logic [3:0] code);
        logic [5:0] dots;
        dots = BLANK;
        case (code)
            4'd0:    dots = 6'b000111;
            4'd1:    dots = 6'b001000;
            4'd2:    dots = 6'b001010;
            4'd3:    dots = 6'b001100;
            4'd4:    dots = 6'b001101;
            4'd5:    dots = 6'b001001;
            4'd6:    dots = 6'b001110;
            4'd7:    dots = 6'b001111;
            4'd8:    dots = 6'b001011;
            4'd9:    dots = 6'b000101;
            4'd10:   dots = 6'b010011;
            4'd11:   dots = 6'b000011;
            4'd12:   dots = 6'b100001;
            4'd13:   dots = 6'b010010;
            4'd14:   dots = 6'b111111;
            default: dots = BLANK;
        endcase
        return dots;
    endfunction

endpackage

// File: rtl/braille_sym_fifo.sv
// Symbol FIFO: registered head, no fall-through, push ignored while full.
// Flush clears occupancy exactly like reset.
module braille_sym_fifo
    import braille_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/braille_scroll_display.sv
// Braille window driver: FIFO-buffered symbols shown NUM_CELLS at a time,
// either scrolled in one cell per dwell period or paged a window at a time.
module braille_scroll_display
    import braille_pkg::*;
#(
    parameter int NUM_CELLS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int DWELL      = 50_000_000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0]                      sym_in,
    input  logic                            sym_valid,
    output logic                            sym_ready,
    input  logic                            mode,
    input  logic                            enable,
    input  logic                            flush,
    output logic [6*NUM_CELLS-1:0]          cells_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            busy,
    output logic                            step
);

    localparam int DW = $clog2(DWELL);
    localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_CELLS - 1);

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] dwell_cnt;
    logic [IW-1:0] idx;
    logic          mode_q;
    logic [5:0]    cells [NUM_CELLS];

    logic [3:0]    head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          do_shift;
    logic          do_load;
    logic [5:0]    new_cell;
    logic          any_lit;

    braille_sym_fifo #(
        .DATA_W (4),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (sym_valid),
        .data  (sym_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign sym_ready = !full;
    assign busy      = (state != S_IDLE);
    assign any_lit   = |cells_out;

    always_comb begin
        cells_out = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            cells_out[6*i +: 6] = cells[i];
        end
    end

    // An empty FIFO feeds blanks, which is how scroll mode drains the window.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        do_shift   = 1'b0;
        do_load    = 1'b0;
        new_cell   = empty ? BLANK : decode(head);
        if (enable) begin
            case (state)
                S_IDLE: begin
                    if (!empty) next_state = mode ? S_LOAD : S_SHIFT;
                end
                S_SHIFT: begin
                    do_shift   = 1'b1;
                    pop        = !empty;
                    next_state = S_DWELL;
                end
                S_LOAD: begin
                    do_load = 1'b1;
                    pop     = !empty;
                    if (idx == IDX_LAST) next_state = S_DWELL;
                end
                S_DWELL: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        if (!empty)
                            next_state = mode_q ? S_LOAD : S_SHIFT;
                        else if (!mode_q && any_lit)
                            next_state = S_SHIFT;
                        else
                            next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            idx       <= '0;
            mode_q    <= 1'b0;
            step      <= 1'b0;
            for (int i = 0; i < NUM_CELLS; i++) cells[i] <= BLANK;
        end else begin
            state <= next_state;
            step  <= do_shift || do_load;
            if (enable && state == S_IDLE && !empty) mode_q <= mode;
            if (enable) begin
                if (state == S_DWELL && dwell_cnt != DWELL_LAST)
                    dwell_cnt <= dwell_cnt + DW'(1);
                else
                    dwell_cnt <= '0;
            end
            if (do_load) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            if (do_shift) begin
                for (int i = 0; i < NUM_CELLS - 1; i++) cells[i] <= cells[i+1];
                cells[NUM_CELLS-1] <= new_cell;
            end
            if (do_load) cells[idx] <= new_cell;
        end
    end

endmodule

// File: tb/tb_braille_scroll_display.sv
// Scoreboard bench: expected windows are queued with stimulus and checked
// against cells_out on every step pulse, together with the pulse spacing.
module tb_braille_scroll_display;

    localparam logic [5:0] Z  = 6'b000111;
    localparam logic [5:0] A  = 6'b001000;
    localparam logic [5:0] B  = 6'b001010;
    localparam logic [5:0] C3 = 6'b001100;
    localparam logic [5:0] G  = 6'b001111;
    localparam logic [5:0] H  = 6'b001011;
    localparam logic [5:0] I9 = 6'b000101;
    localparam logic [5:0] J  = 6'b010011;
    localparam logic [5:0] F  = 6'b111111;
    localparam logic [5:0] O  = 6'b000000;

    typedef struct {
        logic [23:0] cells;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sym_in = '0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic        mode = 1'b0;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic [23:0] cells_out;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        step;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_step = 0;
    int   n;
    exp_t sb[$];

    braille_scroll_display #(
        .NUM_CELLS  (4),
        .FIFO_DEPTH (4),
        .DWELL      (4)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .mode       (mode),
        .enable     (enable),
        .flush      (flush),
        .cells_out  (cells_out),
        .fifo_count (fifo_count),
        .busy       (busy),
        .step       (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] win(input logic [5:0] c0, input logic [5:0] c1,
                                        input logic [5:0] c2, input logic [5:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic expect_win(input logic [23:0] w, input int gap);
        exp_t e;
        e.cells = w;
        e.gap   = gap;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (step) begin
            check("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cells", 32'(cells_out), 32'(e.cells));
                if (e.gap != 0) check("gap", 32'(cyc - last_step), 32'(e.gap));
            end
            last_step = cyc;
        end
    end

    task automatic push_sym(input logic [3:0] c);
        sym_in    = c;
        sym_valid = 1'b1;
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic wait_step(input string tag, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!step && cnt < 60);
        check(tag, 32'(step), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 100);
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_cells"}, 32'(cells_out), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(sym_ready), 32'd1);
        check({tag, "_step"}, 32'(step), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_cleared("rst");

        // scroll two symbols, then four blank shifts empty the window
        @(posedge clk); #1;
        expect_win(win(O, O, O, A), 0);
        expect_win(win(O, O, A, B), 5);
        expect_win(win(O, A, B, O), 5);
        expect_win(win(A, B, O, O), 5);
        expect_win(win(B, O, O, O), 5);
        expect_win(win(O, O, O, O), 5);
        mode = 1'b0;
        sym_in = 4'd1;
        sym_valid = 1'b1;
        @(posedge clk); #1;
        sym_in = 4'd2;
        @(negedge clk);
        check("lat_count1", 32'(fifo_count), 32'd1);
        check("lat_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        sym_valid = 1'b0;
        @(negedge clk);
        check("lat_count2", 32'(fifo_count), 32'd2);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_cells0", 32'(cells_out), 32'd0);
        wait_step("lat_step", n);
        check("lat_edges", 32'(n), 32'd1);
        wait_idle("scroll_idle");
        check("scroll_blank", 32'(cells_out), 32'd0);

        // reset in DWELL with three symbols still queued
        @(posedge clk); #1;
        expect_win(win(O, O, O, C3), 0);
        push_sym(4'd3);
        push_sym(4'd4);
        push_sym(4'd5);
        push_sym(4'd6);
        @(negedge clk);
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_cleared("mid_rst");

        // page: one window loaded cell by cell, then held
        @(posedge clk); #1;
        mode = 1'b1;
        expect_win(win(F, O, O, O), 0);
        expect_win(win(F, Z, O, O), 1);
        expect_win(win(F, Z, O, O), 1);
        expect_win(win(F, Z, O, O), 1);
        push_sym(4'd14);
        push_sym(4'd0);
        push_sym(4'd15);
        wait_idle("page_idle");
        check("page_held", 32'(cells_out), 32'(win(F, Z, O, O)));
        check("page_count", 32'(fifo_count), 32'd0);

        // fill while frozen; the fifth symbol must be refused
        enable = 1'b0;
        mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("ready_fill", 32'(sym_ready), 32'(k < 4));
            push_sym(4'(7 + k));
        end
        @(negedge clk);
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(sym_ready), 32'd0);
        check("frozen_idle", 32'(busy), 32'd0);
        expect_win(win(Z, O, O, G), 0);
        expect_win(win(O, O, G, H), 5);
        expect_win(win(O, G, H, I9), 15);
        expect_win(win(G, H, I9, J), 5);
        expect_win(win(H, I9, J, O), 5);
        expect_win(win(I9, J, O, O), 5);
        expect_win(win(J, O, O, O), 5);
        expect_win(win(O, O, O, O), 5);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_step("drain_s1", n);
        wait_step("drain_s2", n);
        @(posedge clk); #1;
        @(posedge clk); #1;
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 9) begin
                check("freeze_cells", 32'(cells_out), 32'(win(O, O, G, H)));
                check("freeze_count", 32'(fifo_count), 32'd2);
                check("freeze_busy", 32'(busy), 32'd1);
                check("freeze_step", 32'(step), 32'd0);
            end
            @(posedge clk); #1;
        end
        enable = 1'b1;
        wait_idle("drain_idle");

        // flush part-way through a page load
        mode = 1'b1;
        enable = 1'b0;
        for (int k = 0; k < 4; k++) push_sym(4'd14);
        expect_win(win(F, O, O, O), 0);
        expect_win(win(F, F, O, O), 1);
        enable = 1'b1;
        wait_step("load_s1", n);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_cleared("flush");
        repeat (12) @(negedge clk);
        check("post_flush_busy", 32'(busy), 32'd0);
        check("post_flush_cells", 32'(cells_out), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
